// File: rtl/wave_uart_sender_if.sv
// Bus between the waveform UART sender, its requester and the sample buffer.
// The slave modport is the sender itself; the master modport is the host/buffer side.
interface wave_uart_sender_if;
    logic        start;
    logic [15:0] wavenum;
    logic [11:0] rd_data;
    logic [9:0]  rd_addr;
    logic        UART_TX;
    logic        busy;
    logic        done;

    modport slave (
        input  start,
        input  wavenum,
        input  rd_data,
        output rd_addr,
        output UART_TX,
        output busy,
        output done
    );

    modport master (
        output start,
        output wavenum,
        output rd_data,
        input  rd_addr,
        input  UART_TX,
        input  busy,
        input  done
    );
endinterface

// File: rtl/wave_uart_sender.sv
// Serialises one waveform frame (header, wavenum, 12-bit samples, trailer) as 8N1 UART.
// A one-byte holding register lets the control FSM run a byte ahead of the line, so frames are gapless.
module wave_uart_sender #(
    parameter int unsigned CLKS_PER_BIT = 434,
    parameter int unsigned NUM_SAMPLES  = 1000
) (
    input logic               clk,
    input logic               reset,
    wave_uart_sender_if.slave bus
);

    localparam int unsigned CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [9:0]       LAST_ADDR = 10'(NUM_SAMPLES - 1);
    localparam logic [3:0]       STOP_IDX  = 4'd9;

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_HEADER  = 3'd1;
    localparam logic [2:0] S_FETCH   = 3'd2;
    localparam logic [2:0] S_SEND_HI = 3'd3;
    localparam logic [2:0] S_SEND_LO = 3'd4;
    localparam logic [2:0] S_TRAILER = 3'd5;
    localparam logic [2:0] S_DONE    = 3'd6;

    logic [2:0]       state_q,    state_d;
    logic [15:0]      wavenum_q,  wavenum_d;
    logic [11:0]      sample_q,   sample_d;
    logic [9:0]       addr_q,     addr_d;
    logic             hdr_idx_q,  hdr_idx_d;
    logic             fetch_ph_q, fetch_ph_d;
    logic             tail_q,     tail_d;
    logic [7:0]       nb_q,       nb_d;
    logic             nb_valid_q, nb_valid_d;
    logic             active_q,   active_d;
    logic [7:0]       shift_q,    shift_d;
    logic [3:0]       bit_idx_q,  bit_idx_d;
    logic [CNT_W-1:0] clk_cnt_q,  clk_cnt_d;
    logic             tx_q,       tx_d;
    logic             busy_q,     busy_d;
    logic             done_q,     done_d;
    logic             byte_end_c;

    assign byte_end_c = active_q && (clk_cnt_q == CNT_LAST) && (bit_idx_q == STOP_IDX);

    // Next-state logic: line shifter first, then the byte-sequencing FSM.
    always_comb begin
        state_d    = state_q;
        wavenum_d  = wavenum_q;
        sample_d   = sample_q;
        addr_d     = addr_q;
        hdr_idx_d  = hdr_idx_q;
        fetch_ph_d = fetch_ph_q;
        tail_d     = tail_q;
        nb_d       = nb_q;
        nb_valid_d = nb_valid_q;
        active_d   = active_q;
        shift_d    = shift_q;
        bit_idx_d  = bit_idx_q;
        clk_cnt_d  = clk_cnt_q;
        tx_d       = tx_q;
        busy_d     = busy_q;
        done_d     = 1'b0;

        // Bit 0 is the start bit, 1..8 data LSB first, 9 the stop bit.
        if (active_q) begin
            if (clk_cnt_q == CNT_LAST) begin
                clk_cnt_d = '0;
                if (bit_idx_q == STOP_IDX) begin
                    if (nb_valid_q) begin
                        shift_d    = nb_q;
                        nb_valid_d = 1'b0;
                        bit_idx_d  = '0;
                        tx_d       = 1'b0;
                    end else begin
                        active_d = 1'b0;
                    end
                end else begin
                    bit_idx_d = bit_idx_q + 4'd1;
                    tx_d      = (bit_idx_q == 4'd8) ? 1'b1 : shift_q[bit_idx_q[2:0]];
                end
            end else begin
                clk_cnt_d = clk_cnt_q + CNT_W'(1);
            end
        end

        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    state_d   = S_HEADER;
                    busy_d    = 1'b1;
                    wavenum_d = bus.wavenum;
                    hdr_idx_d = 1'b0;
                    tail_d    = 1'b0;
                    active_d  = 1'b1;
                    shift_d   = 8'hAA;
                    bit_idx_d = '0;
                    clk_cnt_d = '0;
                    tx_d      = 1'b0;
                end
            end
            S_HEADER: begin
                if (!nb_valid_q) begin
                    nb_valid_d = 1'b1;
                    if (!hdr_idx_q) begin
                        nb_d      = wavenum_q[15:8];
                        hdr_idx_d = 1'b1;
                    end else begin
                        nb_d       = wavenum_q[7:0];
                        addr_d     = '0;
                        fetch_ph_d = 1'b0;
                        state_d    = S_FETCH;
                    end
                end
            end
            S_FETCH: begin
                // First cycle presents the address, second captures the buffer output.
                if (!fetch_ph_q) begin
                    fetch_ph_d = 1'b1;
                end else begin
                    sample_d = bus.rd_data;
                    state_d  = S_SEND_HI;
                end
            end
            S_SEND_HI: begin
                if (!nb_valid_q) begin
                    nb_d       = {4'h0, sample_q[11:8]};
                    nb_valid_d = 1'b1;
                    state_d    = S_SEND_LO;
                end
            end
            S_SEND_LO: begin
                if (!nb_valid_q) begin
                    nb_d       = sample_q[7:0];
                    nb_valid_d = 1'b1;
                    if (addr_q == LAST_ADDR) begin
                        state_d = S_TRAILER;
                    end else begin
                        addr_d     = addr_q + 10'd1;
                        fetch_ph_d = 1'b0;
                        state_d    = S_FETCH;
                    end
                end
            end
            S_TRAILER: begin
                // Queue 0x55, then finish on the edge its stop bit ends.
                if (!tail_q) begin
                    if (!nb_valid_q) begin
                        nb_d       = 8'h55;
                        nb_valid_d = 1'b1;
                        tail_d     = 1'b1;
                    end
                end else if (byte_end_c && !nb_valid_q) begin
                    state_d = S_DONE;
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            wavenum_q  <= '0;
            sample_q   <= '0;
            addr_q     <= '0;
            hdr_idx_q  <= 1'b0;
            fetch_ph_q <= 1'b0;
            tail_q     <= 1'b0;
            nb_q       <= '0;
            nb_valid_q <= 1'b0;
            active_q   <= 1'b0;
            shift_q    <= '0;
            bit_idx_q  <= '0;
            clk_cnt_q  <= '0;
            tx_q       <= 1'b1;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            wavenum_q  <= wavenum_d;
            sample_q   <= sample_d;
            addr_q     <= addr_d;
            hdr_idx_q  <= hdr_idx_d;
            fetch_ph_q <= fetch_ph_d;
            tail_q     <= tail_d;
            nb_q       <= nb_d;
            nb_valid_q <= nb_valid_d;
            active_q   <= active_d;
            shift_q    <= shift_d;
            bit_idx_q  <= bit_idx_d;
            clk_cnt_q  <= clk_cnt_d;
            tx_q       <= tx_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign bus.rd_addr = addr_q;
    assign bus.UART_TX = tx_q;
    assign bus.busy    = busy_q;
    assign bus.done    = done_q;

endmodule

// File: tb/tb_wave_uart_sender.sv
// Bench for wave_uart_sender: three parameterisations run side by side, each checked every
// cycle against a frame model that derives the expected line level from the byte list.
module tb_wave_uart_sender;

    localparam int CPB_P [3] = '{4, 2, 434};
    localparam int N_P   [3] = '{2, 1024, 1};
    localparam logic [7:0] EXP_BASIC [8] = '{8'hAA, 8'h12, 8'h34, 8'h0A, 8'hBC, 8'h00, 8'h05, 8'h55};

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_v     [3];
    logic        start_v   [3];
    logic [15:0] wav_v     [3];
    logic [11:0] rd_data_v [3];
    logic        tx_o      [3];
    logic        busy_o    [3];
    logic        done_o    [3];
    logic [9:0]  addr_o    [3];

    wave_uart_sender_if if_a ();
    wave_uart_sender_if if_b ();
    wave_uart_sender_if if_c ();

    assign if_a.start   = start_v[0];
    assign if_a.wavenum = wav_v[0];
    assign if_a.rd_data = rd_data_v[0];
    assign tx_o[0]      = if_a.UART_TX;
    assign busy_o[0]    = if_a.busy;
    assign done_o[0]    = if_a.done;
    assign addr_o[0]    = if_a.rd_addr;
    assign if_b.start   = start_v[1];
    assign if_b.wavenum = wav_v[1];
    assign if_b.rd_data = rd_data_v[1];
    assign tx_o[1]      = if_b.UART_TX;
    assign busy_o[1]    = if_b.busy;
    assign done_o[1]    = if_b.done;
    assign addr_o[1]    = if_b.rd_addr;
    assign if_c.start   = start_v[2];
    assign if_c.wavenum = wav_v[2];
    assign if_c.rd_data = rd_data_v[2];
    assign tx_o[2]      = if_c.UART_TX;
    assign busy_o[2]    = if_c.busy;
    assign done_o[2]    = if_c.done;
    assign addr_o[2]    = if_c.rd_addr;

    wave_uart_sender #(.CLKS_PER_BIT(4),   .NUM_SAMPLES(2))    dut_a (.clk(clk), .reset(rst_v[0]), .bus(if_a));
    wave_uart_sender #(.CLKS_PER_BIT(2),   .NUM_SAMPLES(1024)) dut_b (.clk(clk), .reset(rst_v[1]), .bus(if_b));
    wave_uart_sender #(.CLKS_PER_BIT(434), .NUM_SAMPLES(1))    dut_c (.clk(clk), .reset(rst_v[2]), .bus(if_c));

    logic [11:0] mem [3][1024];
    logic        hist_a [65536];
    logic        m_act [3];
    int          m_e0 [3];
    logic [15:0] m_wav [3];
    logic        rst_seen [3];
    int          done_cnt [3];
    int          last_done [3];
    int          prev_addr [3];
    int          visits_b = 0;
    int          e = 0;
    int          nvec = 0;
    int          nfail = 0;

    // Synchronous sample buffer: data for an address appears one cycle later.
    always @(posedge clk) begin
        for (int i = 0; i < 3; i++) rd_data_v[i] <= mem[i][addr_o[i]];
    end

    task automatic chk(input string name, input int act, input int exp_v);
        nvec++;
        if (act != exp_v) begin
            nfail++;
            $display("FAIL %s @edge %0d: got %0h, expected %0h", name, e, act, exp_v);
        end
    endtask

    function automatic int flen(input int i);
        return (4 + 2 * N_P[i]) * 10 * CPB_P[i];
    endfunction

    function automatic logic [7:0] byte_at(input int i, input int j);
        int          k;
        logic [11:0] s;
        if (j == 0) return 8'hAA;
        if (j == 1) return m_wav[i][15:8];
        if (j == 2) return m_wav[i][7:0];
        if (j == 3 + 2 * N_P[i]) return 8'h55;
        k = (j - 3) / 2;
        s = mem[i][k];
        if (((j - 3) % 2) == 0) return {4'h0, s[11:8]};
        return s[7:0];
    endfunction

    function automatic logic exp_bit(input int i, input int bp);
        int         b;
        logic [7:0] by;
        b = bp % 10;
        if (b == 0) return 1'b0;
        if (b == 9) return 1'b1;
        by = byte_at(i, bp / 10);
        return by[b-1];
    endfunction

    // Model update on each edge, then compare the settled outputs.
    initial begin
        for (int i = 0; i < 3; i++) begin
            m_act[i] = 1'b0; m_e0[i] = 0; m_wav[i] = '0; done_cnt[i] = 0;
            last_done[i] = 0; prev_addr[i] = 0; rst_seen[i] = 1'b0;
        end
        forever begin
            @(posedge clk);
            e++;
            for (int i = 0; i < 3; i++) begin
                rst_seen[i] = rst_v[i];
                if (rst_v[i]) begin
                    m_act[i] = 1'b0;
                end else if (start_v[i] && (!m_act[i] || e >= m_e0[i] + flen(i) + 2)) begin
                    m_act[i] = 1'b1;
                    m_e0[i]  = e;
                    m_wav[i] = wav_v[i];
                end
            end
            #1;
            for (int i = 0; i < 3; i++) begin
                int   d;
                logic etx, ebusy, edone, ok;
                d = e - m_e0[i];
                etx = 1'b1; ebusy = 1'b0; edone = 1'b0;
                if (m_act[i] && d < flen(i)) begin
                    etx = exp_bit(i, d / CPB_P[i]);
                    ebusy = 1'b1;
                end else if (m_act[i] && d == flen(i)) begin
                    edone = 1'b1;
                end
                chk($sformatf("tx%0d", i), int'(tx_o[i]), int'(etx));
                chk($sformatf("busy%0d", i), int'(busy_o[i]), int'(ebusy));
                chk($sformatf("done%0d", i), int'(done_o[i]), int'(edone));
                if (rst_seen[i]) chk($sformatf("rst_addr%0d", i), int'(addr_o[i]), 0);
                if (edone) chk($sformatf("last_addr%0d", i), int'(addr_o[i]), N_P[i] - 1);
                if (int'(addr_o[i]) != prev_addr[i]) begin
                    ok = (int'(addr_o[i]) == 0) ||
                         (int'(addr_o[i]) == prev_addr[i] + 1 && int'(addr_o[i]) <= N_P[i] - 1);
                    chk($sformatf("addr_step%0d", i), int'(ok), 1);
                    if (i == 1 && int'(addr_o[i]) == prev_addr[i] + 1) visits_b++;
                    prev_addr[i] = int'(addr_o[i]);
                end
                if (done_o[i]) begin
                    done_cnt[i]++;
                    last_done[i] = e;
                end
            end
            hist_a[e[15:0]] = tx_o[0];
        end
    end

    task automatic wait_done(input int i, input int from, input int budget, input string name);
        int n = 0;
        while (done_cnt[i] <= from && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (done_cnt[i] <= from) chk({name, "_timeout"}, 0, 1);
    endtask

    task automatic pulse_a(input logic [15:0] w, output int ea);
        wav_v[0] = w;
        start_v[0] = 1'b1;
        @(negedge clk);
        ea = e;
        start_v[0] = 1'b0;
    endtask

    // Decodes instance A's line mid-bit from the recorded history.
    task automatic decode_chk(input int ea, input string name);
        logic [7:0] by;
        for (int j = 0; j < 8; j++) begin
            for (int b = 0; b < 8; b++) by[b] = hist_a[16'(ea + (10 * j + 1 + b) * 4 + 2)];
            chk($sformatf("%s_byte%0d", name, j), int'(by), int'(EXP_BASIC[j]));
        end
    endtask

    initial begin
        int ea, eb, dc, guard;
        for (int i = 0; i < 3; i++) begin
            rst_v[i] = 1'b1; start_v[i] = 1'b0; wav_v[i] = '0;
            for (int k = 0; k < 1024; k++) mem[i][k] = 12'($urandom);
        end
        start_v[0] = 1'b1;
        mem[0][0] = 12'hABC;
        mem[0][1] = 12'h005;
        repeat (3) @(negedge clk);
        for (int i = 0; i < 3; i++) rst_v[i] = 1'b0;
        start_v[0] = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("reset_tx%0d", i), int'(tx_o[i]), 1);
            chk($sformatf("reset_busy%0d", i), int'(busy_o[i]), 0);
            chk($sformatf("reset_done%0d", i), int'(done_o[i]), 0);
            chk($sformatf("reset_addr%0d", i), int'(addr_o[i]), 0);
        end

        wav_v[1] = 16'($urandom);
        wav_v[2] = 16'($urandom);
        start_v[1] = 1'b1;
        start_v[2] = 1'b1;
        @(negedge clk);
        eb = e;
        start_v[1] = 1'b0;
        start_v[2] = 1'b0;

        repeat (100) @(negedge clk);
        chk("idle_dones", done_cnt[0], 0);

        // Basic frame with literal byte and latency expectations.
        dc = done_cnt[0];
        pulse_a(16'h1234, ea);
        wait_done(0, dc, 1000, "basic");
        chk("basic_latency", last_done[0] - ea, 320);
        decode_chk(ea, "basic");

        // Second start while busy must be ignored.
        repeat (5) @(negedge clk);
        dc = done_cnt[0];
        pulse_a(16'h1234, ea);
        repeat (49) @(negedge clk);
        wav_v[0] = 16'hFFFF;
        start_v[0] = 1'b1;
        @(negedge clk);
        start_v[0] = 1'b0;
        wait_done(0, dc, 1000, "busy_start");
        repeat (20) @(negedge clk);
        chk("busy_start_dones", done_cnt[0] - dc, 1);
        decode_chk(ea, "busy_start");

        // Start held through the done cycle: accepted only on the cycle after done.
        dc = done_cnt[0];
        wav_v[0] = 16'h1234;
        start_v[0] = 1'b1;
        wait_done(0, dc, 1000, "held_start");
        @(negedge clk);
        @(negedge clk);
        start_v[0] = 1'b0;
        chk("done_cycle_tx", int'(hist_a[16'(last_done[0] + 1)]), 1);
        chk("after_done_tx", int'(tx_o[0]), 0);
        chk("after_done_busy", int'(busy_o[0]), 1);
        ea = e;
        dc = done_cnt[0];
        wait_done(0, dc, 1000, "held_frame");
        decode_chk(ea, "held_frame");

        // Reset in the middle of a frame, then a clean frame.
        repeat (3) @(negedge clk);
        pulse_a(16'h1234, ea);
        repeat (99) @(negedge clk);
        rst_v[0] = 1'b1;
        @(negedge clk);
        rst_v[0] = 1'b0;
        chk("midrst_tx", int'(tx_o[0]), 1);
        chk("midrst_busy", int'(busy_o[0]), 0);
        chk("midrst_done", int'(done_o[0]), 0);
        dc = done_cnt[0];
        pulse_a(16'h1234, ea);
        wait_done(0, dc, 1000, "post_rst");
        decode_chk(ea, "post_rst");

        // Random frames, ignored starts and occasional mid-frame resets.
        for (int it = 0; it < 12; it++) begin
            guard = 0;
            while (busy_o[0] && guard < 1000) begin
                @(negedge clk);
                guard++;
            end
            if (busy_o[0]) chk("rand_idle_timeout", 0, 1);
            repeat (2) @(negedge clk);
            mem[0][0] = 12'($urandom);
            mem[0][1] = 12'($urandom);
            repeat ($urandom_range(0, 7)) @(negedge clk);
            dc = done_cnt[0];
            pulse_a(16'($urandom), ea);
            if ($urandom_range(0, 3) == 0) begin
                repeat ($urandom_range(1, 300)) @(negedge clk);
                rst_v[0] = 1'b1;
                @(negedge clk);
                rst_v[0] = 1'b0;
            end else begin
                repeat ($urandom_range(1, 250)) @(negedge clk);
                wav_v[0] = 16'($urandom);
                start_v[0] = 1'b1;
                @(negedge clk);
                start_v[0] = 1'b0;
                wait_done(0, dc, 1000, "rand_done");
            end
        end

        // Long frame (1024 samples) and slow bit clock (434 cycles/bit).
        wait_done(1, 0, 60000, "big_frame");
        wait_done(2, 0, 60000, "slow_frame");
        chk("big_latency", last_done[1] - eb, 41040);
        chk("slow_latency", last_done[2] - eb, 26040);
        chk("big_visits", visits_b, 1023);
        chk("big_dones", done_cnt[1], 1);
        repeat (5) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

endmodule
